// File: rtl/jtcop_obj_buffer.sv
// rtl/jtcop_obj_buffer.sv - double-buffered object line buffer with front-to-back priority
// Draw side does read-modify-write into the hidden bank; display side reads then clears.
module jtcop_obj_buffer #(
  parameter int AW       = 9,
  parameter bit KEEP_OLD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_data,
  input  logic          buf_we,
  output logic          ready,
  output logic [7:0]    obj_pxl
);
  typedef enum logic {INIT, RUN} state_t;
  localparam int DEPTH = 2**(AW+1);

  state_t      state_q, state_d;
  logic [AW:0] init_q, init_d;
  logic        run;

  logic          lhbl_q, disp_q;
  logic          s0_vld_q, s0_bank_q;
  logic [AW-1:0] s0_addr_q;
  logic [7:0]    s0_data_q;
  logic          s1_vld_q, s1_bank_q, s1_fwd_q;
  logic [AW-1:0] s1_addr_q;
  logic [7:0]    s1_data_q;
  logic [7:0]    rda_q;
  logic          rdb_vld_q, blank_q, hold_vld_q;
  logic [AW:0]   rdb_addr_q;
  logic [7:0]    hold_q, obj_q;

  logic          accept, opaque, s1_we, fwd;
  logic          wa_en;
  logic [AW:0]   wa_addr;
  logic [7:0]    wa_data;

  logic [7:0] mem [DEPTH];

  assign run     = (state_q == RUN);
  assign ready   = run;
  assign obj_pxl = obj_q;

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    if (state_q == INIT) begin
      init_d = init_q + (AW+1)'(1);
      if (&init_q) state_d = RUN;
    end
  end

  always_comb begin
    accept  = run && buf_we && (buf_data[3:0] != 4'd0);
    opaque  = s1_fwd_q || (rda_q[3:0] != 4'd0);
    s1_we   = s1_vld_q && (!KEEP_OLD || !opaque);
    // RAM lags one write behind stage 0, so a hit on the stage-1 write is forwarded as opaque
    fwd     = s1_we && s0_vld_q && (s1_addr_q == s0_addr_q) && (s1_bank_q == s0_bank_q);
    wa_en   = 1'b0;
    wa_addr = init_q;
    wa_data = 8'd0;
    if (!run) begin
      wa_en = 1'b1;
    end else if (s1_we) begin
      wa_en   = 1'b1;
      wa_addr = {s1_bank_q, s1_addr_q};
      wa_data = s1_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_q     <= '0;
      lhbl_q     <= 1'b0;
      disp_q     <= 1'b0;
      s0_vld_q   <= 1'b0;
      s0_bank_q  <= 1'b0;
      s0_addr_q  <= '0;
      s0_data_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_bank_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_fwd_q   <= 1'b0;
      rdb_vld_q  <= 1'b0;
      rdb_addr_q <= '0;
      blank_q    <= 1'b0;
      hold_vld_q <= 1'b0;
      obj_q      <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      lhbl_q   <= LHBL;
      if (lhbl_q && !LHBL) disp_q <= ~disp_q;

      s0_vld_q <= accept;
      if (accept) begin
        s0_addr_q <= buf_addr;
        s0_data_q <= buf_data;
        s0_bank_q <= ~disp_q;
      end
      s1_vld_q  <= s0_vld_q;
      s1_addr_q <= s0_addr_q;
      s1_data_q <= s0_data_q;
      s1_bank_q <= s0_bank_q;
      s1_fwd_q  <= fwd;

      rdb_vld_q <= run && pxl_cen;
      if (run && pxl_cen) begin
        rdb_addr_q <= {disp_q, hdump};
        blank_q    <= ~LHBL;
        obj_q      <= (blank_q || !hold_vld_q) ? 8'd0 : hold_q;
      end
      if (rdb_vld_q) hold_vld_q <= 1'b1;
    end
  end

  // Port A: draw/init write and draw read; port B: scan read then clear
  always_ff @(posedge clk) begin
    rda_q <= mem[{s0_bank_q, s0_addr_q}];
    if (rdb_vld_q) hold_q <= mem[rdb_addr_q];
    if (wa_en) mem[wa_addr] <= wa_data;
    if (rdb_vld_q) mem[rdb_addr_q] <= 8'd0;
  end
endmodule

// File: tb/tb_jtcop_obj_buffer.sv
// tb/tb_jtcop_obj_buffer.sv - checks both priority modes against a per-line array model
module tb_jtcop_obj_buffer;
  localparam int NX = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic [8:0] hdump = '0;
  logic [8:0] buf_addr = '0;
  logic [7:0] buf_data = '0;
  logic       buf_we = 1'b0;
  logic       rdy0, rdy1;
  logic [7:0] obj0, obj1;

  int tests = 0;
  int fails = 0;
  int disp  = 0;
  logic [7:0] mdl [2][2][NX+1];

  always #5 clk = ~clk;

  jtcop_obj_buffer #(.AW(9), .KEEP_OLD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .ready(rdy0), .obj_pxl(obj0));

  jtcop_obj_buffer #(.AW(9), .KEEP_OLD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .ready(rdy1), .obj_pxl(obj1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 2; b++)
        for (int x = 0; x <= NX; x++) mdl[k][b][x] = 8'd0;
    disp = 0;
  endtask

  // Model: front-to-back keeps the first opaque pixel, back-to-front keeps the last
  task automatic do_write(input int x, input logic [7:0] d);
    int b;
    b = 1 - disp;
    buf_we   = 1'b1;
    buf_addr = 9'(x);
    buf_data = d;
    if (d[3:0] != 4'd0) begin
      if (mdl[0][b][x][3:0] == 4'd0) mdl[0][b][x] = d;
      mdl[1][b][x] = d;
    end
    tick();
  endtask

  task automatic flush();
    buf_we = 1'b0;
    repeat (3) tick();
  endtask

  task automatic swap();
    LHBL = 1'b1;
    tick();
    LHBL = 1'b0;
    tick();
    disp = 1 - disp;
  endtask

  task automatic scan(input string tag, input logic lhbl);
    logic [7:0] exp0, exp1, prev0, prev1;
    prev0 = 8'd0;
    prev1 = 8'd0;
    LHBL  = lhbl;
    for (int i = 0; i <= NX; i++) begin
      exp0 = lhbl ? mdl[0][disp][i] : 8'd0;
      exp1 = lhbl ? mdl[1][disp][i] : 8'd0;
      mdl[0][disp][i] = 8'd0;
      mdl[1][disp][i] = 8'd0;
      hdump   = 9'(i);
      pxl_cen = 1'b1;
      tick();
      pxl_cen = 1'b0;
      if (i > 0) begin
        check($sformatf("%s keep x=%0d", tag, i-1), obj0, prev0);
        check($sformatf("%s last x=%0d", tag, i-1), obj1, prev1);
      end
      prev0 = exp0;
      prev1 = exp1;
      repeat (3) tick();
    end
  endtask

  task automatic init_check(input string tag);
    int nz;
    for (int c = 1; c <= 1024; c++) begin
      tick();
      check($sformatf("%s ready0 c=%0d", tag, c), {7'd0, rdy0}, (c == 1024) ? 8'd1 : 8'd0);
      check($sformatf("%s ready1 c=%0d", tag, c), {7'd0, rdy1}, (c == 1024) ? 8'd1 : 8'd0);
      check($sformatf("%s obj c=%0d", tag, c), obj0 | obj1, 8'd0);
    end
    nz = 0;
    for (int a = 0; a < 1024; a++)
      if (dut0.mem[a] !== 8'd0 || dut1.mem[a] !== 8'd0) nz++;
    check($sformatf("%s ram nonzero", tag), 8'(nz), 8'd0);
  endtask

  task automatic random_round(input string tag);
    int n;
    n = $urandom_range(1, 12);
    for (int w = 0; w < n; w++) begin
      do_write($urandom_range(0, NX-1), 8'($urandom_range(0, 255)));
      buf_we = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    flush();
    swap();
    scan(tag, 1'b1);
  endtask

  initial begin
    model_clear();
    repeat (3) tick();
    check("reset ready", {7'd0, rdy0}, 8'd0);
    check("reset obj", obj0, 8'd0);
    rst = 1'b0;
    init_check("init");

    do_write(10, 8'h35); flush(); swap(); scan("basic", 1'b1);

    do_write(20, 8'h12); do_write(20, 8'h47); flush(); swap(); scan("prio b2b", 1'b1);
    do_write(20, 8'h12); buf_we = 1'b0; repeat (5) tick();
    do_write(20, 8'h47); flush(); swap(); scan("prio gap", 1'b1);

    do_write(30, 8'h10); do_write(30, 8'h08); flush(); swap(); scan("transp", 1'b1);

    do_write(40, 8'h22); flush(); swap(); scan("clr1", 1'b1);
    swap(); scan("clr2", 1'b1);
    swap(); scan("clr3", 1'b1);

    do_write(5, 8'h66); flush(); swap(); scan("blank", 1'b0);
    swap(); scan("blank2", 1'b1);
    swap(); scan("blank3", 1'b1);

    for (int r = 0; r < 6; r++) random_round($sformatf("rnd%0d", r));

    // Mid-operation reset with a draw and a scan read in flight
    do_write(7, 8'h55);
    do_write(8, 8'h77);
    pxl_cen = 1'b1;
    hdump   = 9'd3;
    rst     = 1'b1;
    #1;
    check("midrst ready", {7'd0, rdy0}, 8'd0);
    check("midrst obj", obj0 | obj1, 8'd0);
    buf_we  = 1'b0;
    pxl_cen = 1'b0;
    LHBL    = 1'b1;
    tick();
    tick();
    model_clear();
    rst = 1'b0;
    init_check("reinit");

    for (int r = 0; r < 3; r++) random_round($sformatf("post%0d", r));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
